// File: rtl/cia_arb_pkg.sv
// Shared types and constants for the round-robin carry-increment adder arbiter.
package cia_arb_pkg;

    localparam int CIA_W = 32;
    localparam int OPS_W = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/CIA.sv
// 32-bit carry-increment adder: each 4-bit block adds locally, then the incoming
// block carry increments the partial sum instead of rippling through the block.
module CIA
    import cia_arb_pkg::*;
(
    input  logic [CIA_W-1:0] a,
    input  logic [CIA_W-1:0] b,
    input  logic             cin,
    output logic [CIA_W-1:0] sum,
    output logic             cout,
    output logic             OF
);

    localparam int BLK  = 4;
    localparam int NBLK = CIA_W / BLK;

    logic [NBLK:0] blk_c_s;

    assign blk_c_s[0] = cin;

    for (genvar g = 0; g < NBLK; g++) begin : g_blk
        logic [BLK:0] raw_s;
        logic [BLK:0] inc_s;

        assign raw_s = {1'b0, a[g*BLK +: BLK]} + {1'b0, b[g*BLK +: BLK]};
        assign inc_s = {1'b0, raw_s[BLK-1:0]} + {{BLK{1'b0}}, blk_c_s[g]};
        assign sum[g*BLK +: BLK] = inc_s[BLK-1:0];
        // Local carry and increment carry can never both be set
        assign blk_c_s[g+1] = raw_s[BLK] | inc_s[BLK];
    end

    assign cout = blk_c_s[NBLK];
    assign OF   = (sum[CIA_W-1] ^ a[CIA_W-1]) & ~(a[CIA_W-1] ^ b[CIA_W-1]);

endmodule

// File: rtl/cia_arbiter.sv
// Round-robin arbiter sharing one CIA adder between NREQ valid/ready requesters,
// returning registered results on a single back-pressured response channel.
module cia_arbiter
    import cia_arb_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [CIA_W*NREQ-1:0]   req_a,
    input  logic [CIA_W*NREQ-1:0]   req_b,
    input  logic [NREQ-1:0]         req_cin,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDW-1:0]          rsp_id,
    output logic [CIA_W-1:0]        rsp_sum,
    output logic                    rsp_cout,
    output logic                    rsp_of,
    output logic                    busy,
    output logic [OPS_W-1:0]        ops_done
);

    state_e             state_q;
    logic [IDW-1:0]     rr_ptr_q;
    logic [CIA_W-1:0]   a_q, b_q;
    logic               cin_q;
    logic [IDW-1:0]     id_q;
    logic               rsp_valid_q, rsp_cout_q, rsp_of_q, busy_q;
    logic [IDW-1:0]     rsp_id_q;
    logic [CIA_W-1:0]   rsp_sum_q;
    logic [OPS_W-1:0]   ops_done_q;

    logic [CIA_W-1:0]   a_arr_s [NREQ];
    logic [CIA_W-1:0]   b_arr_s [NREQ];
    logic [IDW-1:0]     cand_s, winner_s;
    logic               found_s, hs_s;
    logic [CIA_W-1:0]   sum_s;
    logic               cout_s, of_s;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr_s[i] = req_a[i*CIA_W +: CIA_W];
        assign b_arr_s[i] = req_b[i*CIA_W +: CIA_W];
    end

    // Round-robin pick: first valid requester at or after rr_ptr, wrapping in IDW bits
    always_comb begin
        found_s  = 1'b0;
        winner_s = '0;
        cand_s   = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_s = rr_ptr_q + IDW'(k);
            if (!found_s && req_valid[cand_s]) begin
                found_s  = 1'b1;
                winner_s = cand_s;
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Grant is combinational so a handshake completes in the same IDLE cycle
    always_comb begin
        req_ready = '0;
        if (!rst && (state_q == S_IDLE) && found_s) begin
            req_ready[winner_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    assign hs_s = |(req_valid & req_ready);

    CIA u_cia (
        .a    (a_q),
        .b    (b_q),
        .cin  (cin_q),
        .sum  (sum_s),
        .cout (cout_s),
        .OF   (of_s)
    );

    // Control FSM with operand latching and registered response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= 1'b0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_of_q    <= 1'b0;
            busy_q      <= 1'b0;
            ops_done_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (hs_s) begin
                        a_q      <= a_arr_s[winner_s];
                        b_q      <= b_arr_s[winner_s];
                        cin_q    <= req_cin[winner_s];
                        id_q     <= winner_s;
                        rr_ptr_q <= winner_s + 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= S_EXEC;
                    end else begin
                        state_q  <= S_IDLE;
                    end
                end
                S_EXEC: begin
                    rsp_sum_q   <= sum_s;
                    rsp_cout_q  <= cout_s;
                    rsp_of_q    <= of_s;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        ops_done_q  <= ops_done_q + 1'b1;
                        state_q     <= S_IDLE;
                    end else begin
                        state_q     <= S_RESP;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_of    = rsp_of_q;
    assign busy      = busy_q;
    assign ops_done  = ops_done_q;

endmodule

// File: tb/tb_cia_arbiter.sv
// Directed self-checking bench for cia_arbiter with four requesters.
module tb_cia_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a, req_b;
    logic [3:0]   req_cin;
    logic         rsp_valid, rsp_ready;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_sum;
    logic         rsp_cout, rsp_of, busy;
    logic [15:0]  ops_done;

    int checks = 0;
    int errors = 0;

    cia_arbiter #(.NREQ(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_of    (rsp_of),
        .busy      (busy),
        .ops_done  (ops_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    // Drives one request, handshakes, and stops once rsp_valid is seen
    task automatic do_op(input int idx, input logic [31:0] a, input logic [31:0] b, input logic cin);
        int n;
        req_a[idx*32 +: 32] = a;
        req_b[idx*32 +: 32] = b;
        req_cin[idx]        = cin;
        req_valid           = 4'b0001 << idx;
        #1;
        n = 0;
        while (req_ready[idx] !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        checks++;
        if (req_ready[idx] !== 1'b1) begin
            errors++;
            $display("FAIL grant_timeout idx=%0d req_ready=%b required bit set", idx, req_ready);
        end
        tick();
        req_valid = 4'b0000;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL rsp_timeout idx=%0d rsp_valid=%b required 1", idx, rsp_valid);
        end
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 4'b1111;
        tick();
        tick();
        checks++;
        if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
        checks++;
        if ({rsp_valid, busy, rsp_cout, rsp_of} !== 4'b0000 || rsp_sum !== 32'h0 || rsp_id !== 2'd0 || ops_done !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b busy=%b sum=%h id=%0d ops=%h exp all zero", rsp_valid, busy, rsp_sum, rsp_id, ops_done);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL post_reset_grant got=%b exp=0001", req_ready); end
        req_valid = 4'b0000;
        #1;
    endtask

    task automatic test_single();
        req_a[64 +: 32] = 32'h0000_0005;
        req_b[64 +: 32] = 32'h0000_0003;
        req_cin[2]      = 1'b1;
        req_valid       = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant got=%b exp=0100", req_ready); end
        tick();
        req_valid = 4'b0000;
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL single_exec got v=%b busy=%b exp v=0 busy=1", rsp_valid, busy);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_sum !== 32'h0000_0009 || rsp_cout !== 1'b0 || rsp_of !== 1'b0 || rsp_id !== 2'd2) begin
            errors++;
            $display("FAIL single_rsp got v=%b sum=%h c=%b of=%b id=%0d exp v=1 sum=00000009 c=0 of=0 id=2",
                     rsp_valid, rsp_sum, rsp_cout, rsp_of, rsp_id);
        end
        finish_rsp();
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || ops_done !== 16'd1) begin
            errors++; $display("FAIL single_done got v=%b busy=%b ops=%0d exp v=0 busy=0 ops=1", rsp_valid, busy, ops_done);
        end
    endtask

    task automatic test_carry_overflow();
        do_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        checks++;
        if (rsp_sum !== 32'h0 || rsp_cout !== 1'b1 || rsp_of !== 1'b0 || rsp_id !== 2'd0) begin
            errors++; $display("FAIL carry_out got sum=%h c=%b of=%b id=%0d exp sum=0 c=1 of=0 id=0", rsp_sum, rsp_cout, rsp_of, rsp_id);
        end
        finish_rsp();
        do_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        checks++;
        if (rsp_sum !== 32'h8000_0000 || rsp_cout !== 1'b0 || rsp_of !== 1'b1 || rsp_id !== 2'd0) begin
            errors++; $display("FAIL overflow got sum=%h c=%b of=%b id=%0d exp sum=80000000 c=0 of=1 id=0", rsp_sum, rsp_cout, rsp_of, rsp_id);
        end
        finish_rsp();
        do_op(0, 32'h0F0F_0F0F, 32'h00F0_F0F0, 1'b1);
        checks++;
        if (rsp_sum !== 32'h1000_0000 || rsp_cout !== 1'b0 || rsp_of !== 1'b0) begin
            errors++; $display("FAIL ripple_carry got sum=%h c=%b of=%b exp sum=10000000 c=0 of=0", rsp_sum, rsp_cout, rsp_of);
        end
        finish_rsp();
        checks++;
        if (ops_done !== 16'd4) begin errors++; $display("FAIL carry_ops got=%0d exp=4", ops_done); end
    endtask

    task automatic test_backpressure();
        do_op(1, 32'h1234_0000, 32'h0000_5678, 1'b0);
        req_valid = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_sum !== 32'h1234_5678 || rsp_id !== 2'd1 || req_ready !== 4'b0000 || busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d got v=%b sum=%h id=%0d rdy=%b busy=%b exp v=1 sum=12345678 id=1 rdy=0000 busy=1",
                         c, rsp_valid, rsp_sum, rsp_id, req_ready, busy);
            end
        end
        req_valid = 4'b0000;
        finish_rsp();
        checks++;
        if (ops_done !== 16'd5 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL bp_release got ops=%0d busy=%b v=%b exp ops=5 busy=0 v=0", ops_done, busy, rsp_valid);
        end
        tick();
        checks++;
        if (ops_done !== 16'd5) begin errors++; $display("FAIL bp_single_inc got=%0d exp=5", ops_done); end
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_sum [4];
        int order [5];
        exp_sum[0] = 32'h1000_0000; exp_sum[1] = 32'h2000_0002;
        exp_sum[2] = 32'h3000_0002; exp_sum[3] = 32'h4000_0004;
        order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;
        apply_reset();
        req_a = {32'h4000_0000, 32'h3000_0000, 32'h2000_0000, 32'h1000_0000};
        req_b = {32'd3, 32'd2, 32'd1, 32'd0};
        req_cin = 4'b1010;
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        #1;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (req_ready !== (4'b0001 << order[k])) begin
                errors++; $display("FAIL rr_grant k=%0d got=%b exp_id=%0d", k, req_ready, order[k]);
            end
            tick();
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'(order[k]) || rsp_sum !== exp_sum[order[k]]) begin
                errors++;
                $display("FAIL rr_rsp k=%0d got v=%b id=%0d sum=%h exp v=1 id=%0d sum=%h",
                         k, rsp_valid, rsp_id, rsp_sum, order[k], exp_sum[order[k]]);
            end
            tick();
            if (k == 4) req_valid = 4'b0000;
            checks++;
            if (ops_done !== 16'(k + 1) || rsp_valid !== 1'b0) begin
                errors++; $display("FAIL rr_ops k=%0d got ops=%0d v=%b exp ops=%0d v=0", k, ops_done, rsp_valid, k + 1);
            end
        end
        rsp_ready = 1'b0;
        #1;
    endtask

    task automatic test_reset_in_exec();
        // rr_ptr is 1 here, so requester 2 wins and the pointer moves to 3
        req_a[64 +: 32] = 32'h0000_00AA;
        req_b[64 +: 32] = 32'h0000_0011;
        req_cin[2] = 1'b0;
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin errors++; $display("FAIL rie_grant got=%b exp=0100", req_ready); end
        tick();
        req_valid = 4'b0000;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (rsp_valid !== 1'b0 || ops_done !== 16'd0 || busy !== 1'b0) begin
                errors++; $display("FAIL rie_discard cyc=%0d got v=%b ops=%0d busy=%b exp v=0 ops=0 busy=0", c, rsp_valid, ops_done, busy);
            end
            tick();
        end
        req_valid = 4'b1001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL rie_ptr_zero got=%b exp=0001", req_ready); end
        req_valid = 4'b0000;
        do_op(0, 32'h0000_0001, 32'h0000_0001, 1'b0);
        checks++;
        if (rsp_sum !== 32'h2 || rsp_id !== 2'd0) begin
            errors++; $display("FAIL rie_after got sum=%h id=%0d exp sum=00000002 id=0", rsp_sum, rsp_id);
        end
        finish_rsp();
    endtask

    task automatic test_ops_wrap();
        force dut.ops_done_q = 16'hFFFF;
        #1;
        release dut.ops_done_q;
        #1;
        checks++;
        if (ops_done !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload got=%h exp=ffff", ops_done); end
        do_op(3, 32'h0000_0010, 32'h0000_0020, 1'b1);
        checks++;
        if (rsp_sum !== 32'h0000_0031 || rsp_id !== 2'd3) begin
            errors++; $display("FAIL wrap_rsp got sum=%h id=%0d exp sum=00000031 id=3", rsp_sum, rsp_id);
        end
        finish_rsp();
        checks++;
        if (ops_done !== 16'h0000) begin errors++; $display("FAIL wrap_zero got=%h exp=0000", ops_done); end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 4'b0000;
        req_a = '0;
        req_b = '0;
        req_cin = 4'b0000;
        rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_carry_overflow();
        test_backpressure();
        test_round_robin();
        test_reset_in_exec();
        test_ops_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
